// File: rtl/cr_pkg.sv
// Shared types and defaults for the cognitive-radio transmit controller.
package cr_pkg;

  localparam int unsigned CR_N_CH          = 3;
  localparam int unsigned CR_FRAME_LEN     = 100;
  localparam int unsigned CR_SU_FIFO_DEPTH = 8;

  typedef logic [1:0] cr_sym_t;

  typedef enum logic {
    CR_IDLE   = 1'b0,
    CR_ACTIVE = 1'b1
  } cr_tx_state_e;

  localparam logic CR_D_PU = 1'b1;
  localparam logic CR_D_SU = 1'b0;

endpackage

// File: rtl/cr_su_fifo.sv
// Per-channel SU bit buffer: 1-bit push, 0/1/2-bit pop, oldest bit on head_o[1].
module cr_su_fifo
  import cr_pkg::*;
#(
  parameter int unsigned DEPTH = CR_SU_FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             push_bit_i,
  input  logic [1:0]       pop_req_i,
  output logic [1:0]       pop_n_o,
  output cr_sym_t          head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] rd_nxt_c;
  logic             push_ok_c;

  // Pops are limited by the registered count, so a bit pushed this cycle is never popped this cycle.
  assign push_ok_c = push_i && (count_q < CNT_W'(DEPTH));
  assign pop_n_o   = (CNT_W'(pop_req_i) > count_q) ? count_q[1:0] : pop_req_i;
  assign rd_nxt_c  = rd_q + PTR_W'(1);
  assign head_o    = {mem_q[rd_q], mem_q[rd_nxt_c]};
  assign count_o   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok_c) begin
        mem_q[wr_q] <= push_bit_i;
        wr_q        <= wr_q + PTR_W'(1);
      end
      rd_q    <= rd_q + PTR_W'(pop_n_o);
      count_q <= count_q + CNT_W'(push_ok_c) - CNT_W'(pop_n_o);
    end
  end

endmodule

// File: rtl/cr_controller_tx.sv
// Cognitive-radio TX controller: per-channel PU/SU merge into 2-bit slots with frame decision.
// Optional CR_TX_STATS_EN adds saturating sec_frames / ul_count statistics outputs.
module cr_controller_tx
  import cr_pkg::*;
#(
  parameter int unsigned N_CH          = CR_N_CH,
  parameter int unsigned FRAME_LEN     = CR_FRAME_LEN,
  parameter int unsigned SU_FIFO_DEPTH = CR_SU_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [N_CH-1:0]     pu_req,
  input  logic [N_CH-1:0]     pu_valid,
  input  logic [N_CH-1:0]     pu_bit,
  output logic [N_CH-1:0]     pu_ready,
  input  logic [N_CH-1:0]     su_valid,
  input  logic [N_CH-1:0]     su_bit,
  output logic [N_CH-1:0]     su_ready,
  output logic [N_CH-1:0]     ch_valid,
  output logic [2*N_CH-1:0]   ch_sym,
  output logic [N_CH-1:0]     ch_d,
  output logic [N_CH-1:0]     frame_done,
  output logic [N_CH-1:0]     pu_underrun,
  output logic [N_CH-1:0]     su_underrun
`ifdef CR_TX_STATS_EN
  ,
  output logic [16*N_CH-1:0]  sec_frames,
  output logic [16*N_CH-1:0]  ul_count
`endif
);

  localparam int unsigned SLOT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned CNT_W  = $clog2(SU_FIFO_DEPTH + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    cr_tx_state_e      state_q;
    logic [SLOT_W-1:0] slot_q;
    logic              d_q;
    logic              valid_q;
    logic              done_q;
    logic              pu_ul_q;
    logic              su_ul_q;
    cr_sym_t           sym_q;
    cr_sym_t           sym_c;
    cr_sym_t           head_c;
    logic              active_c;
    logic              last_c;
    logic              start_c;
    logic              pu_ul_c;
    logic              su_ul_c;
    logic [1:0]        pop_req_c;
    logic [1:0]        pop_n_c;
    logic [CNT_W-1:0]  count_c;

    assign active_c  = (state_q == CR_ACTIVE);
    assign last_c    = active_c && (slot_q == LAST_SLOT);
    assign start_c   = frame_start && (!active_c || last_c);
    assign pop_req_c = !active_c ? 2'd0 : ((d_q == CR_D_PU) ? 2'd1 : 2'd2);

    cr_su_fifo #(
      .DEPTH(SU_FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (su_valid[c]),
      .push_bit_i(su_bit[c]),
      .pop_req_i (pop_req_c),
      .pop_n_o   (pop_n_c),
      .head_o    (head_c),
      .count_o   (count_c)
    );

    // Slot symbol for the current consume cycle; only meaningful while ACTIVE.
    always_comb begin
      sym_c   = '0;
      pu_ul_c = 1'b0;
      su_ul_c = 1'b0;
      if (d_q == CR_D_PU) begin
        sym_c[1] = pu_valid[c] & pu_bit[c];
        sym_c[0] = (pop_n_c == 2'd1) & head_c[1];
        pu_ul_c  = !pu_valid[c];
        su_ul_c  = (pop_n_c != 2'd1);
      end else begin
        sym_c[1] = (pop_n_c != 2'd0) & head_c[1];
        sym_c[0] = (pop_n_c == 2'd2) & head_c[0];
        su_ul_c  = (pop_n_c != 2'd2);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= CR_IDLE;
        slot_q  <= '0;
        d_q     <= 1'b0;
        valid_q <= 1'b0;
        done_q  <= 1'b0;
        pu_ul_q <= 1'b0;
        su_ul_q <= 1'b0;
        sym_q   <= '0;
      end else begin
        valid_q <= active_c;
        sym_q   <= active_c ? sym_c : cr_sym_t'(0);
        pu_ul_q <= active_c & pu_ul_c;
        su_ul_q <= active_c & su_ul_c;
        done_q  <= last_c;
        case (state_q)
          CR_IDLE: begin
            if (frame_start) begin
              state_q <= CR_ACTIVE;
              slot_q  <= '0;
              d_q     <= pu_req[c];
            end
          end
          CR_ACTIVE: begin
            // A frame_start on the last slot chains straight into the next frame.
            if (last_c) begin
              slot_q <= '0;
              if (frame_start) begin
                d_q <= pu_req[c];
              end else begin
                state_q <= CR_IDLE;
              end
            end else begin
              slot_q <= slot_q + SLOT_W'(1);
            end
          end
          default: state_q <= CR_IDLE;
        endcase
      end
    end

    assign pu_ready[c]       = active_c & (d_q == CR_D_PU) & pu_valid[c];
    assign su_ready[c]       = !rst & (count_c < CNT_W'(SU_FIFO_DEPTH));
    assign ch_valid[c]       = valid_q;
    assign ch_sym[2*c +: 2]  = sym_q;
    assign ch_d[c]           = d_q;
    assign frame_done[c]     = done_q;
    assign pu_underrun[c]    = pu_ul_q;
    assign su_underrun[c]    = su_ul_q;

`ifdef CR_TX_STATS_EN
    logic [15:0] sec_q;
    logic [15:0] ul_q;

    // Saturating counters: SU-owned frames started, and slots with any underrun.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sec_q <= '0;
        ul_q  <= '0;
      end else begin
        if (start_c && (pu_req[c] == CR_D_SU) && (sec_q != 16'hFFFF)) begin
          sec_q <= sec_q + 16'd1;
        end
        if (active_c && (pu_ul_c || su_ul_c) && (ul_q != 16'hFFFF)) begin
          ul_q <= ul_q + 16'd1;
        end
      end
    end

    assign sec_frames[16*c +: 16] = sec_q;
    assign ul_count[16*c +: 16]   = ul_q;
`endif
  end

endmodule

// File: tb/tb_cr_controller_tx.sv
// Self-checking bench for cr_controller_tx against a queue-style behavioural model.
module tb_cr_controller_tx;

  localparam int NCH = 3;
  localparam int FL  = 100;
  localparam int DEP = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic [2:0]   pu_req, pu_valid, pu_bit, pu_ready;
  logic [2:0]   su_valid, su_bit, su_ready;
  logic [2:0]   ch_valid, ch_d, frame_done, pu_underrun, su_underrun;
  logic [5:0]   ch_sym;
`ifdef CR_TX_STATS_EN
  logic [47:0]  sec_frames, ul_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: frame slot index (-1 idle), decision, SU bits oldest at bit 0.
  int          m_slot[NCH];
  bit          m_d[NCH];
  logic [63:0] m_fb[NCH];
  int          m_fn[NCH];
  logic [2:0]  e_valid, e_done, e_pul, e_sul;
  logic [5:0]  e_sym;

  always #5 clk = ~clk;

  cr_controller_tx dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .pu_req     (pu_req),
    .pu_valid   (pu_valid),
    .pu_bit     (pu_bit),
    .pu_ready   (pu_ready),
    .su_valid   (su_valid),
    .su_bit     (su_bit),
    .su_ready   (su_ready),
    .ch_valid   (ch_valid),
    .ch_sym     (ch_sym),
    .ch_d       (ch_d),
    .frame_done (frame_done),
    .pu_underrun(pu_underrun),
    .su_underrun(su_underrun)
`ifdef CR_TX_STATS_EN
    ,
    .sec_frames (sec_frames),
    .ul_count   (ul_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_slot[c] = -1;
      m_d[c]    = 1'b0;
      m_fb[c]   = '0;
      m_fn[c]   = 0;
    end
    e_valid = '0; e_done = '0; e_pul = '0; e_sul = '0; e_sym = '0;
  endtask

  function automatic bit pop(input int c);
    bit b;
    b       = m_fb[c][0];
    m_fb[c] = m_fb[c] >> 1;
    m_fn[c] = m_fn[c] - 1;
    return b;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      int pre;
      bit b1, b0;
      pre = m_fn[c];
      b1 = 1'b0; b0 = 1'b0;
      e_valid[c] = 1'b0; e_done[c] = 1'b0; e_pul[c] = 1'b0; e_sul[c] = 1'b0;
      if (m_slot[c] >= 0) begin
        e_valid[c] = 1'b1;
        e_done[c]  = (m_slot[c] == FL - 1);
        if (m_d[c]) begin
          b1 = pu_valid[c] & pu_bit[c];
          e_pul[c] = !pu_valid[c];
          if (m_fn[c] > 0) b0 = pop(c); else e_sul[c] = 1'b1;
        end else begin
          if (m_fn[c] > 0) b1 = pop(c); else e_sul[c] = 1'b1;
          if (m_fn[c] > 0) b0 = pop(c); else e_sul[c] = 1'b1;
        end
      end
      e_sym[2*c+1] = b1;
      e_sym[2*c]   = b0;
      if (su_valid[c] && pre < DEP) begin
        m_fb[c][m_fn[c]] = su_bit[c];
        m_fn[c] = m_fn[c] + 1;
      end
      if (frame_start && (m_slot[c] < 0 || m_slot[c] == FL - 1)) begin
        m_slot[c] = 0;
        m_d[c]    = pu_req[c];
      end else if (m_slot[c] == FL - 1) begin
        m_slot[c] = -1;
      end else if (m_slot[c] >= 0) begin
        m_slot[c] = m_slot[c] + 1;
      end
    end
  endtask

  task automatic chk_outs(input string pfx);
    logic [2:0] e_d;
    for (int c = 0; c < NCH; c++) e_d[c] = m_d[c];
    chk({pfx, ".ch_valid"}, 32'(ch_valid), 32'(e_valid));
    chk({pfx, ".ch_sym"}, 32'(ch_sym), 32'(e_sym));
    chk({pfx, ".ch_d"}, 32'(ch_d), 32'(e_d));
    chk({pfx, ".frame_done"}, 32'(frame_done), 32'(e_done));
    chk({pfx, ".pu_underrun"}, 32'(pu_underrun), 32'(e_pul));
    chk({pfx, ".su_underrun"}, 32'(su_underrun), 32'(e_sul));
  endtask

  // One clock: check same-cycle handshakes, take the edge, check registered slot outputs.
  task automatic step();
    logic [2:0] exp_pr, exp_sr;
    #1;
    for (int c = 0; c < NCH; c++) begin
      exp_pr[c] = (m_slot[c] >= 0) && m_d[c] && pu_valid[c];
      exp_sr[c] = (m_fn[c] < DEP);
    end
    chk("pu_ready", 32'(pu_ready), 32'(exp_pr));
    chk("su_ready", 32'(su_ready), 32'(exp_sr));
    @(posedge clk);
    model_edge();
    #1;
    chk_outs("slot");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk_outs("rst");
    chk("rst.su_ready", 32'(su_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_outs("rst_hold");
    chk("rst_hold.su_ready", 32'(su_ready), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] d6;
    int         done_cnt;

    rst = 1'b1; frame_start = 1'b0;
    pu_req = '0; pu_valid = '0; pu_bit = '0; su_valid = '0; su_bit = '0;
    model_reset();
    do_reset();

    // PU owns all channels, PU stream 1010.., SU stream all zeros.
    pu_req = 3'b111; pu_valid = 3'b111; su_valid = 3'b111; su_bit = 3'b000;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i <= FL; i++) begin
      pu_bit = (i % 2 == 0) ? 3'b111 : 3'b000;
      step();
      if (frame_done[0]) done_cnt++;
      if (i == 0) chk("s2.slot0_sym", 32'(ch_sym[1:0]), 32'(2'b10));
      if (i == 1) chk("s2.slot1_sym", 32'(ch_sym[1:0]), 32'(2'b00));
      if (i == FL - 1) chk("s2.last_done", 32'(frame_done), 32'(3'b111));
    end
    chk("s2.done_count", 32'(done_cnt), 32'd1);

    // Mid-run reset clears leftover SU bits.
    do_reset();

    // SU owns the channels; prefilled 8-bit SU stream, then drain into underrun.
    pat = 8'b1100_1011;
    pu_req = 3'b000; pu_valid = 3'b000;
    for (int i = 0; i < DEP; i++) begin
      su_valid = 3'b111;
      su_bit   = {3{pat[i]}};
      step();
    end
    su_valid = 3'b000;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i <= FL; i++) begin
      pu_valid = 3'($urandom);
      pu_bit   = 3'($urandom);
      step();
      if (i == 0) chk("s3.slot0_sym", 32'(ch_sym[1:0]), 32'(2'b11));
      if (i == 1) chk("s3.slot1_sym", 32'(ch_sym[1:0]), 32'(2'b01));
      if (i == 3) chk("s3.slot3_sul", 32'(su_underrun), 32'd0);
      if (i == 4) chk("s3.slot4_sul", 32'(su_underrun), 32'(3'b111));
    end

    // PU frame with a PU gap on slot 5, then zero-gap chaining into an SU frame.
    pu_req = 3'b111; pu_valid = 3'b111; su_valid = 3'b111;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      pu_valid = (i == 5) ? 3'b000 : 3'b111;
      pu_bit   = 3'($urandom);
      su_bit   = 3'($urandom);
      if (i == FL - 1) begin
        frame_start = 1'b1;
        pu_req      = 3'b000;
      end
      step();
      if (i == 4) chk("s4.slot4_pul", 32'(pu_underrun), 32'd0);
      if (i == 5) chk("s4.slot5_pul", 32'(pu_underrun), 32'(3'b111));
      if (i == 6) chk("s4.slot6_pul", 32'(pu_underrun), 32'd0);
    end
    frame_start = 1'b0;
    for (int i = 0; i <= FL; i++) begin
      su_valid = 3'($urandom);
      su_bit   = 3'($urandom);
      pu_valid = 3'($urandom);
      step();
      if (i == 0) begin
        chk("s5.first_valid", 32'(ch_valid), 32'(3'b111));
        chk("s5.first_d", 32'(ch_d), 32'd0);
      end
    end

    // Fill FIFOs in IDLE past capacity, then a frame that sees a stray frame_start.
    su_valid = 3'b111;
    for (int i = 0; i < DEP + 4; i++) begin
      su_bit = 3'($urandom);
      step();
    end
    #1;
    chk("s6.full_ready", 32'(su_ready), 32'd0);
    su_valid = 3'b000;
    d6 = 3'($urandom);
    pu_req = d6; pu_valid = 3'b111;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i <= FL; i++) begin
      pu_bit = 3'($urandom);
      frame_start = (i == 30);
      if (i == 30) pu_req = ~d6;
      step();
      if (i == 31) chk("s6.d_held", 32'(ch_d), 32'(d6));
    end
    frame_start = 1'b0;

    // Random traffic with an asynchronous reset mid-stream.
    for (int i = 0; i < 600; i++) begin
      pu_req      = 3'($urandom);
      pu_valid    = 3'($urandom | $urandom);
      pu_bit      = 3'($urandom);
      su_valid    = 3'($urandom);
      su_bit      = 3'($urandom);
      frame_start = ($urandom_range(0, 29) == 0);
      if (i == 300) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
